serial_deserializer: RTL and testbench

Serial-in, parallel-out deserializer built on the flip-flop primitives. It collects WIDTH serial bits, qualified by `sin_valid`, into a shift register. Each completed word moves into a one-entry holding register that is drained through a valid/ready handshake. It sits directly downstream of the D flip-flop stage and consumes its registered Q output as the serial bit stream.

---
 rtl/serial_deserializer_pkg.sv | 9 +
 rtl/dff_rst_bank.sv | 20 ++
 rtl/serial_deserializer.sv | 117 +++++++++++
 tb/tb_serial_deserializer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_deserializer_pkg.sv
// Shared encodings for the serial deserializer holding-register FSM.
package serial_deserializer_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/dff_rst_bank.sv
// Bank of D flip-flops with load enable and asynchronous active-low reset.
module dff_rst_bank #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in, parallel-out deserializer with a one-entry valid/ready holding register.
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sin,
  input  logic                      sin_valid,
  input  logic                      clear,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [$clog2(WIDTH)-1:0]  bit_cnt,
  output logic                      overrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic             sreg_en_c;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] bit_cnt_d;
  logic             word_done_c;
  logic             load_c;
  logic             overrun_q;
  logic             overrun_d;
  hold_state_e      state_q;
  hold_state_e      state_d;

  // Shift path and bit counter; clear wins over an incoming bit.
  always_comb begin
    sreg_en_c   = clear | sin_valid;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    word_done_c = 1'b0;
    if (clear) begin
      sreg_d    = '0;
      bit_cnt_d = '0;
    end else if (sin_valid) begin
      if (MSB_FIRST) begin
        sreg_d = {sreg_q[WIDTH-2:0], sin};
      end else begin
        sreg_d = {sin, sreg_q[WIDTH-1:1]};
      end
      if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
        word_done_c = 1'b1;
        bit_cnt_d   = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  dff_rst_bank #(.WIDTH(WIDTH)) u_sreg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sreg_en_c),
    .d     (sreg_d),
    .q     (sreg_q)
  );

  // Holding FSM: a completed word replaces the held one only if it drains this edge.
  always_comb begin
    state_d   = state_q;
    load_c    = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      EMPTY: begin
        if (word_done_c) begin
          load_c  = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (dout_ready) begin
          if (word_done_c) begin
            load_c = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end else if (word_done_c) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  dff_rst_bank #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_c),
    .d     (sreg_d),
    .q     (dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      bit_cnt_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout_valid = (state_q == FULL);
  assign bit_cnt    = bit_cnt_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer (MSB-first and LSB-first instances).
module tb_serial_deserializer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             clk;
  logic             rst_n;
  logic             sin;
  logic             sin_valid;
  logic             clear;
  logic             dout_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;
  logic [WIDTH-1:0] dout_l;
  logic             dout_valid_l;
  logic [CNT_W-1:0] bit_cnt_l;
  logic             overrun_l;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] sb_q[$];

  serial_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .clear      (clear),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .bit_cnt    (bit_cnt),
    .overrun    (overrun)
  );

  serial_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .clear      (clear),
    .dout       (dout_l),
    .dout_valid (dout_valid_l),
    .dout_ready (dout_ready),
    .bit_cnt    (bit_cnt_l),
    .overrun    (overrun_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshake monitor: the word accepted on the coming edge must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && dout_valid && dout_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        check_eq("sb_word", 32'(dout), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    tick();
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit push);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i]);
    sin_valid = 1'b0;
    if (push) sb_q.push_back(w);
  endtask

  task automatic drain();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    rst_n      = 1'b0;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    clear      = 1'b0;
    dout_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_dout", 32'(dout), 32'h0);
    check_eq("rst_valid", 32'(dout_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Asynchronous reset mid-word
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check_eq("cnt_3", 32'(bit_cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_cnt", 32'(bit_cnt), 32'h0);
    check_eq("arst_dout", 32'(dout), 32'h0);
    check_eq("arst_valid", 32'(dout_valid), 32'h0);
    check_eq("arst_ovr", 32'(overrun), 32'h0);
    check_eq("arst_cnt_l", 32'(bit_cnt_l), 32'h0);
    sin_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // MSB-first and LSB-first assembly of 1,0,1,1,0,0,1,0
    w = 8'hB2;
    for (int i = WIDTH - 1; i >= 4; i--) send_bit(w[i]);
    check_eq("cnt_mid", 32'(bit_cnt), 32'd4);
    check_eq("valid_mid", 32'(dout_valid), 32'h0);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
    sin_valid = 1'b0;
    sb_q.push_back(w);
    check_eq("msb_dout", 32'(dout), 32'hB2);
    check_eq("msb_valid", 32'(dout_valid), 32'h1);
    check_eq("msb_cnt", 32'(bit_cnt), 32'h0);
    check_eq("lsb_dout", 32'(dout_l), 32'h4D);
    tick();
    check_eq("hold_stable", 32'(dout), 32'hB2);
    drain();
    check_eq("drained_valid", 32'(dout_valid), 32'h0);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check_eq("ready_empty_noop", 32'(dout_valid), 32'h0);

    // Back-to-back: new word lands on the same edge the held word drains
    send_word(8'hA5, 1'b1);
    w = 8'h3C;
    for (int i = WIDTH - 1; i >= 1; i--) send_bit(w[i]);
    check_eq("b2b_hold", 32'(dout), 32'hA5);
    dout_ready = 1'b1;
    send_bit(w[0]);
    sin_valid = 1'b0;
    sb_q.push_back(w);
    dout_ready = 1'b0;
    check_eq("b2b_valid", 32'(dout_valid), 32'h1);
    check_eq("b2b_dout", 32'(dout), 32'h3C);
    check_eq("b2b_ovr", 32'(overrun), 32'h0);
    drain();

    // Continuous stream with ready held high
    dout_ready = 1'b1;
    send_word(8'h96, 1'b1);
    send_word(8'h0F, 1'b1);
    tick();
    dout_ready = 1'b0;
    check_eq("stream_valid", 32'(dout_valid), 32'h0);
    check_eq("stream_ovr", 32'(overrun), 32'h0);

    // Overrun: second word dropped, held word unchanged
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b0);
    check_eq("ovr_dout", 32'(dout), 32'h11);
    check_eq("ovr_flag", 32'(overrun), 32'h1);
    drain();
    check_eq("ovr_sticky", 32'(overrun), 32'h1);
    check_eq("ovr_drained", 32'(dout_valid), 32'h0);

    // Clear mid-word discards partial bits
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    clear = 1'b1;
    send_bit(1'b1);
    clear = 1'b0;
    sin_valid = 1'b0;
    check_eq("clr_cnt", 32'(bit_cnt), 32'h0);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    sin_valid = 1'b0;
    check_eq("clr_no_early", 32'(dout_valid), 32'h0);
    send_bit(1'b1);
    sin_valid = 1'b0;
    sb_q.push_back(8'hFF);
    check_eq("clr_dout", 32'(dout), 32'hFF);
    drain();

    // Gaps between bits with random sin while sin_valid is low
    w = 8'h5A;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      send_bit(w[i]);
      sin_valid = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        sin = 1'($urandom_range(0, 1));
        tick();
      end
    end
    sb_q.push_back(w);
    check_eq("gap_dout", 32'(dout), 32'h5A);
    drain();

    check_eq("sb_left", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
